// File: rtl/mul_tree_result_drain.sv
// Result drain for mul_tree_bf16: buffers strobed lane groups in a small FIFO and
// serializes the valid lanes, lowest index first, onto a valid/ready word stream.
module mul_tree_result_drain #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4*DW-1:0]            res_in,
    input  logic [3:0]                 res_stb,
    output logic [DW-1:0]              out_data,
    output logic [1:0]                 out_lane,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    input  logic                       ovf_clr,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic {StEmpty, StSend} state_e;

    // FIFO storage; no reset needed since level gates every read.
    logic [4*DW-1:0] mem_data [DEPTH];
    logic [3:0]      mem_stb  [DEPTH];

    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [4*DW-1:0] hold_q, hold_d;
    logic [3:0]      rm_q, rm_d;
    logic            ovf_q, ovf_d;

    state_e          state;
    logic            fifo_empty;
    logic            fifo_full;
    logic            hs;
    logic            pop;
    logic            push;
    logic            drop;
    logic [3:0]      rm_clr;
    logic [1:0]      lane;
    logic [DW-1:0]   lane_data [4];

    always_comb begin
        state = (rm_q == 4'd0) ? StEmpty : StSend;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_data[i] = hold_q[i*DW +: DW];
        end
    end

    // Lowest set bit of the remaining mask picks the lane on the bus.
    always_comb begin
        lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rm_q[i]) begin
                lane = 2'(i);
            end
        end
    end

    always_comb begin
        rm_clr     = rm_q & (rm_q - 4'd1);
        out_valid  = (state == StSend);
        out_lane   = lane;
        out_last   = (state == StSend) && (rm_clr == 4'd0);
        out_data   = (state == StSend) ? lane_data[lane] : '0;
        overflow   = ovf_q;
        level      = level_q;

        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LW'(DEPTH));
        hs         = out_valid && out_ready;
        pop        = !fifo_empty && ((state == StEmpty) || (hs && out_last));
        push       = (res_stb != 4'd0) && (!fifo_full || pop);
        drop       = (res_stb != 4'd0) && !push;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        hold_d  = hold_q;
        rm_d    = rm_q;
        ovf_d   = ovf_q;

        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A load replaces the mask outright, so it takes priority over clearing a bit.
        if (pop) begin
            hold_d = mem_data[rptr_q];
            rm_d   = mem_stb[rptr_q];
        end else if (hs) begin
            rm_d = rm_clr;
        end

        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wptr_q] <= res_in;
            mem_stb[wptr_q]  <= res_stb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
            hold_q  <= '0;
            rm_q    <= 4'd0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
            hold_q  <= hold_d;
            rm_q    <= rm_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_mul_tree_result_drain.sv
// Bench for mul_tree_result_drain: scoreboard of expected words plus vector table
// and hand-written sequences for latency, backpressure, overflow and reset.
module tb_mul_tree_result_drain;

    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [4*DW-1:0] res_in = '0;
    logic [3:0]      res_stb = 4'd0;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_lane;
    logic            out_last;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic            ovf_clr = 1'b0;
    logic            overflow;
    logic [2:0]      level;

    mul_tree_result_drain #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .res_in   (res_in),
        .res_stb  (res_stb),
        .out_data (out_data),
        .out_lane (out_lane),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .ovf_clr  (ovf_clr),
        .overflow (overflow),
        .level    (level)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  lane;
        logic        last;
    } word_t;

    typedef struct {
        logic [3:0]  stb;
        logic [63:0] data;
        int          exp_words;
    } vec_t;

    word_t q[$];
    int    passes = 0;
    int    total = 0;
    int    hs_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected words: strobed lanes ascending, last = no higher strobe set.
    task automatic model_push(input logic [3:0] stb, input logic [63:0] d);
        word_t w;
        for (int i = 0; i < 4; i++) begin
            if (stb[i]) begin
                w.data = d[i*16 +: 16];
                w.lane = 2'(i);
                w.last = ((stb >> (i + 1)) == 4'd0);
                q.push_back(w);
            end
        end
    endtask

    // Called just after an edge; returns just after the capturing edge.
    task automatic drive_group(input logic [3:0] stb, input logic [63:0] d, input bit accept);
        res_stb = stb;
        res_in  = d;
        if (accept) model_push(stb, d);
        step();
        res_stb = 4'd0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < budget) begin
            step();
            n++;
        end
        check("drain_done", 64'((q.size() == 0) && !out_valid), 64'd1);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_count++;
            if (q.size() == 0) begin
                total++;
                $display("FAIL unexpected_word: got lane %0d data %0h expected none",
                         out_lane, out_data);
            end else begin
                word_t w;
                w = q.pop_front();
                check("word_data", 64'(out_data), 64'(w.data));
                check("word_lane", 64'(out_lane), 64'(w.lane));
                check("word_last", 64'(out_last), 64'(w.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{4'b1010, 64'h1111_2222_3333_4444, 2};
        vecs[1] = '{4'b0001, 64'hAAAA_BBBB_CCCC_DDDD, 1};
        vecs[2] = '{4'b1000, 64'h5555_0000_0000_0000, 1};
        vecs[3] = '{4'b0110, 64'h0000_7777_8888_0000, 2};
        vecs[4] = '{4'b1111, 64'h4000_3F80_C000_BF80, 4};
        vecs[5] = '{4'b0101, 64'h1234_5678_9ABC_DEF0, 2};

        // Reset state
        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_lane", 64'(out_lane), 64'd0);
        check("rst_last", 64'(out_last), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_level", 64'(level), 64'd0);

        // Single full group: latency and back-to-back lanes
        out_ready = 1'b1;
        drive_group(4'hF, {16'h4080, 16'h4040, 16'h4000, 16'h3F80}, 1'b1);
        check("lat_valid_k", 64'(out_valid), 64'd0);
        check("lat_level_k", 64'(level), 64'd1);
        step();
        check("lat_valid_k1", 64'(out_valid), 64'd1);
        check("lat_level_k1", 64'(level), 64'd0);
        repeat (4) step();
        check("full_grp_q_empty", 64'(q.size()), 64'd0);
        check("full_grp_done", 64'(out_valid), 64'd0);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            hs_count = 0;
            drive_group(vecs[i].stb, vecs[i].data, 1'b1);
            wait_drain(20);
            check("vec_words", 64'(hs_count), 64'(vecs[i].exp_words));
        end

        // Backpressure mid-group
        drive_group(4'hF, 64'h0D0D_0C0C_0B0B_0A0A, 1'b1);
        step();
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_lane", 64'(out_lane), 64'(q[0].lane));
            check("bp_data", 64'(out_data), 64'(q[0].data));
            step();
        end
        out_ready = 1'b1;
        wait_drain(20);

        // Overflow: hold + four queued groups, sixth dropped
        out_ready = 1'b0;
        for (int g = 1; g <= 5; g++) begin
            drive_group(4'hF, {4{12'h100, 4'(g)}}, 1'b1);
        end
        check("ovf_level_full", 64'(level), 64'd4);
        check("ovf_before", 64'(overflow), 64'd0);
        check("ovf_hold_valid", 64'(out_valid), 64'd1);
        drive_group(4'hF, 64'hDEAD_DEAD_DEAD_DEAD, 1'b0);
        check("ovf_set", 64'(overflow), 64'd1);
        check("ovf_level_kept", 64'(level), 64'd4);
        out_ready = 1'b1;
        wait_drain(100);
        check("ovf_sticky", 64'(overflow), 64'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", 64'(overflow), 64'd0);

        // Full FIFO with last-lane handshake on the same edge as a new strobe
        out_ready = 1'b0;
        drive_group(4'b0001, 64'h0000_0000_0000_0E01, 1'b1);
        for (int g = 2; g <= 5; g++) begin
            drive_group(4'hF, {4{12'hE00, 4'(g)}}, 1'b1);
        end
        check("fp_level_full", 64'(level), 64'd4);
        res_stb = 4'hF;
        res_in  = 64'hF003_F002_F001_F000;
        model_push(4'hF, 64'hF003_F002_F001_F000);
        out_ready = 1'b1;
        step();
        res_stb = 4'd0;
        out_ready = 1'b0;
        check("fp_level_same", 64'(level), 64'd4);
        check("fp_no_ovf", 64'(overflow), 64'd0);
        out_ready = 1'b1;
        wait_drain(100);

        // Reset mid-burst
        drive_group(4'hF, 64'h9993_9992_9991_9990, 1'b1);
        step();
        step();
        step();
        check("rmb_lane2", 64'(out_lane), 64'd2);
        rst = 1'b1;
        #1;
        check("rmb_valid_async", 64'(out_valid), 64'd0);
        check("rmb_level_async", 64'(level), 64'd0);
        q.delete();
        step();
        step();
        rst = 1'b0;
        step();
        hs_count = 0;
        drive_group(4'b0001, 64'h0000_0000_0000_ABCD, 1'b1);
        check("rmb_lat_valid_k", 64'(out_valid), 64'd0);
        step();
        check("rmb_lat_last", 64'(out_last), 64'd1);
        wait_drain(20);
        check("rmb_words", 64'(hs_count), 64'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
